// File: rtl/vector_op_pkg.sv
// Shared types and result-narrowing helpers for vector_op.
// VECTOR_OP_SATURATE_EN selects clamping on narrowing; otherwise results wrap.
package vector_op_pkg;

    typedef enum logic {IDLE, RUN} state_t;
    typedef enum logic {MODE_ELEM, MODE_DOT} mode_t;

    // Products and sums are widened to this width before range checks.
    localparam int WIDE_W = 64;
    typedef logic signed [WIDE_W-1:0] wide_t;

    function automatic wide_t range_max(input int width);
        return (wide_t'(1) <<< (width - 1)) - wide_t'(1);
    endfunction

    function automatic wide_t range_min(input int width);
        return -(wide_t'(1) <<< (width - 1));
    endfunction

    function automatic logic out_of_range(input wide_t value, input int width);
        return (value > range_max(width)) || (value < range_min(width));
    endfunction

    // Result is returned sign-extended so callers can simply take the low bits.
    function automatic wide_t narrow(input wide_t value, input int width);
        wide_t res;
`ifdef VECTOR_OP_SATURATE_EN
        if (value > range_max(width)) begin
            res = range_max(width);
        end else if (value < range_min(width)) begin
            res = range_min(width);
        end else begin
            res = value;
        end
`else
        res = (value <<< (WIDE_W - width)) >>> (WIDE_W - width);
`endif
        return res;
    endfunction

endpackage

// File: rtl/vector_lane_mul.sv
// One lane of vector_op: signed multiply, fixed-point shift, narrowing and
// overflow detection (narrowing mode follows VECTOR_OP_SATURATE_EN).
module vector_lane_mul
    import vector_op_pkg::*;
#(
    parameter int A_CELL_WIDTH      = 8,
    parameter int B_CELL_WIDTH      = 8,
    parameter int RESULT_CELL_WIDTH = 8,
    parameter int FRACTION          = 4
) (
    input  logic [A_CELL_WIDTH-1:0]                     a,
    input  logic [B_CELL_WIDTH-1:0]                     b,
    output logic signed [A_CELL_WIDTH+B_CELL_WIDTH-1:0] product,
    output logic [RESULT_CELL_WIDTH-1:0]                narrowed,
    output logic                                        overflow
);

    localparam int P_W = A_CELL_WIDTH + B_CELL_WIDTH;

    logic signed [P_W-1:0]    a_ext;
    logic signed [P_W-1:0]    b_ext;
    logic signed [P_W-1:0]    full;
    logic signed [WIDE_W-1:0] wide;

    assign a_ext = {{B_CELL_WIDTH{a[A_CELL_WIDTH-1]}}, a};
    assign b_ext = {{A_CELL_WIDTH{b[B_CELL_WIDTH-1]}}, b};
    assign full  = a_ext * b_ext;

    // The unnarrowed product feeds the dot accumulator.
    assign product  = full >>> FRACTION;
    assign wide     = WIDE_W'(product);
    assign narrowed = RESULT_CELL_WIDTH'(narrow(wide, RESULT_CELL_WIDTH));
    assign overflow = out_of_range(wide, RESULT_CELL_WIDTH);

endmodule

// File: rtl/vector_op.sv
// Lane-wise fixed-point vector multiplier with optional dot product, TILING lanes
// per cycle. Narrowing saturates when VECTOR_OP_SATURATE_EN is defined, else wraps.
module vector_op
    import vector_op_pkg::*;
#(
    parameter int VECTOR_LEN        = 5,
    parameter int A_CELL_WIDTH      = 8,
    parameter int B_CELL_WIDTH      = 8,
    parameter int RESULT_CELL_WIDTH = 8,
    parameter int FRACTION          = 4,
    parameter int TILING            = 1
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    start,
    input  logic                                    mode,
    input  logic [VECTOR_LEN*A_CELL_WIDTH-1:0]      a,
    input  logic [VECTOR_LEN*B_CELL_WIDTH-1:0]      b,
    output logic [VECTOR_LEN*RESULT_CELL_WIDTH-1:0] result,
    output logic [RESULT_CELL_WIDTH-1:0]            dot,
    output logic                                    busy,
    output logic                                    valid,
    output logic                                    error,
    output logic [VECTOR_LEN-1:0]                   overflow_mask
);

    localparam int P_W   = A_CELL_WIDTH + B_CELL_WIDTH;
    localparam int ACC_W = P_W + $clog2(VECTOR_LEN);
    localparam int CNT_W = $clog2(VECTOR_LEN + TILING + 1);

    state_t                              state;
    state_t                              next_state;
    mode_t                               mode_reg;
    logic [VECTOR_LEN*A_CELL_WIDTH-1:0]  a_reg;
    logic [VECTOR_LEN*B_CELL_WIDTH-1:0]  b_reg;
    logic [CNT_W-1:0]                    counter;
    logic signed [ACC_W-1:0]             acc;
    logic                                dot_overflow;

    logic [A_CELL_WIDTH-1:0]             tile_a [TILING];
    logic [B_CELL_WIDTH-1:0]             tile_b [TILING];
    logic [TILING-1:0]                   tile_active;
    logic signed [P_W-1:0]               tile_product [TILING];
    logic [RESULT_CELL_WIDTH-1:0]        tile_narrowed [TILING];
    logic [TILING-1:0]                   tile_overflow;

    logic [VECTOR_LEN-1:0]               lane_write;
    logic [VECTOR_LEN-1:0]               lane_overflow;
    logic [RESULT_CELL_WIDTH-1:0]        lane_data [VECTOR_LEN];

    logic signed [ACC_W-1:0]             tile_sum;
    logic signed [ACC_W-1:0]             acc_next;
    logic signed [WIDE_W-1:0]            acc_wide;
    logic                                last_tile;

    // Gather operands for the lanes of the current tile; lanes past the end stay idle.
    always_comb begin
        for (int t = 0; t < TILING; t++) begin
            tile_a[t]      = '0;
            tile_b[t]      = '0;
            tile_active[t] = (counter + CNT_W'(t)) < CNT_W'(VECTOR_LEN);
            for (int k = 0; k < VECTOR_LEN; k++) begin
                if ((counter + CNT_W'(t)) == CNT_W'(k)) begin
                    tile_a[t] = a_reg[k*A_CELL_WIDTH +: A_CELL_WIDTH];
                    tile_b[t] = b_reg[k*B_CELL_WIDTH +: B_CELL_WIDTH];
                end
            end
        end
    end

    for (genvar t = 0; t < TILING; t++) begin : g_lane
        vector_lane_mul #(
            .A_CELL_WIDTH      (A_CELL_WIDTH),
            .B_CELL_WIDTH      (B_CELL_WIDTH),
            .RESULT_CELL_WIDTH (RESULT_CELL_WIDTH),
            .FRACTION          (FRACTION)
        ) u_lane (
            .a        (tile_a[t]),
            .b        (tile_b[t]),
            .product  (tile_product[t]),
            .narrowed (tile_narrowed[t]),
            .overflow (tile_overflow[t])
        );
    end

    // Scatter tile results back onto their vector lane positions.
    always_comb begin
        lane_write    = '0;
        lane_overflow = '0;
        for (int k = 0; k < VECTOR_LEN; k++) begin
            lane_data[k] = '0;
        end
        for (int k = 0; k < VECTOR_LEN; k++) begin
            for (int t = 0; t < TILING; t++) begin
                if (tile_active[t] && ((counter + CNT_W'(t)) == CNT_W'(k))) begin
                    lane_write[k]    = 1'b1;
                    lane_data[k]     = tile_narrowed[t];
                    lane_overflow[k] = tile_overflow[t];
                end
            end
        end
    end

    always_comb begin
        tile_sum = '0;
        for (int t = 0; t < TILING; t++) begin
            if (tile_active[t]) begin
                tile_sum = tile_sum + ACC_W'(tile_product[t]);
            end
        end
        acc_next  = acc + tile_sum;
        acc_wide  = WIDE_W'(acc_next);
        last_tile = (counter + CNT_W'(TILING)) >= CNT_W'(VECTOR_LEN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_tile) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Operand latch on accept, then per-tile result/flag/accumulator updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg         <= '0;
            b_reg         <= '0;
            mode_reg      <= MODE_ELEM;
            counter       <= '0;
            acc           <= '0;
            dot_overflow  <= 1'b0;
            result        <= '0;
            dot           <= '0;
            valid         <= 1'b0;
            overflow_mask <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                a_reg         <= a;
                b_reg         <= b;
                mode_reg      <= mode_t'(mode);
                counter       <= '0;
                acc           <= '0;
                dot_overflow  <= 1'b0;
                valid         <= 1'b0;
                overflow_mask <= '0;
            end
        end else begin
            for (int k = 0; k < VECTOR_LEN; k++) begin
                if (lane_write[k]) begin
                    result[k*RESULT_CELL_WIDTH +: RESULT_CELL_WIDTH] <= lane_data[k];
                    if (lane_overflow[k]) begin
                        overflow_mask[k] <= 1'b1;
                    end
                end
            end
            counter <= counter + CNT_W'(TILING);
            if (mode_reg == MODE_DOT) begin
                acc <= acc_next;
            end
            if (last_tile) begin
                valid <= 1'b1;
                if (mode_reg == MODE_DOT) begin
                    dot          <= RESULT_CELL_WIDTH'(narrow(acc_wide, RESULT_CELL_WIDTH));
                    dot_overflow <= out_of_range(acc_wide, RESULT_CELL_WIDTH);
                end else begin
                    dot          <= '0;
                    dot_overflow <= 1'b0;
                end
            end
        end
    end

    assign error = (|overflow_mask) | dot_overflow;

endmodule

// File: tb/tb_vector_op.sv
// Self-checking bench for vector_op (TILING=1 and TILING=2 instances) using a
// scoreboard of expected results; expectations follow VECTOR_OP_SATURATE_EN.
module tb_vector_op;

    localparam int VL   = 5;
    localparam int FRAC = 4;
    localparam int W    = VL * 8;

    typedef struct {
        logic [W-1:0] result;
        logic [7:0]   dot;
        logic [VL-1:0] mask;
        logic         err;
        int           edges;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           dut_sel = 0;
    logic         start1, start2;

    logic [W-1:0]  result1, result2, obs_result;
    logic [7:0]    dot1, dot2, obs_dot;
    logic          busy1, busy2, obs_busy;
    logic          valid1, valid2, obs_valid;
    logic          error1, error2, obs_error;
    logic [VL-1:0] mask1, mask2, obs_mask;

    always #5 clk = ~clk;

    assign start1     = start && (dut_sel == 0);
    assign start2     = start && (dut_sel == 1);
    assign obs_result = (dut_sel == 1) ? result2 : result1;
    assign obs_dot    = (dut_sel == 1) ? dot2    : dot1;
    assign obs_busy   = (dut_sel == 1) ? busy2   : busy1;
    assign obs_valid  = (dut_sel == 1) ? valid2  : valid1;
    assign obs_error  = (dut_sel == 1) ? error2  : error1;
    assign obs_mask   = (dut_sel == 1) ? mask2   : mask1;

    vector_op #(
        .VECTOR_LEN(VL), .A_CELL_WIDTH(8), .B_CELL_WIDTH(8),
        .RESULT_CELL_WIDTH(8), .FRACTION(FRAC), .TILING(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode), .a(a), .b(b),
        .result(result1), .dot(dot1), .busy(busy1), .valid(valid1),
        .error(error1), .overflow_mask(mask1)
    );

    vector_op #(
        .VECTOR_LEN(VL), .A_CELL_WIDTH(8), .B_CELL_WIDTH(8),
        .RESULT_CELL_WIDTH(8), .FRACTION(FRAC), .TILING(2)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .mode(mode), .a(a), .b(b),
        .result(result2), .dot(dot2), .busy(busy2), .valid(valid2),
        .error(error2), .overflow_mask(mask2)
    );

    function automatic logic [7:0] narrow8(input int v);
`ifdef VECTOR_OP_SATURATE_EN
        if (v > 127) return 8'h7F;
        if (v < -128) return 8'h80;
`endif
        return 8'(v);
    endfunction

    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic md, input int tiling, input string nm);
        exp_t e;
        int p;
        int acc;
        logic signed [7:0] ai, bi;
        logic dovf;
        e.result = '0;
        e.mask   = '0;
        e.dot    = '0;
        acc      = 0;
        for (int i = 0; i < VL; i++) begin
            ai = av[i*8 +: 8];
            bi = bv[i*8 +: 8];
            p  = (int'(ai) * int'(bi)) >>> FRAC;
            e.mask[i] = (p > 127) || (p < -128);
            e.result[i*8 +: 8] = narrow8(p);
            acc += p;
        end
        dovf = 1'b0;
        if (md) begin
            e.dot = narrow8(acc);
            dovf  = (acc > 127) || (acc < -128);
        end
        e.err   = (|e.mask) || dovf;
        e.edges = (VL + tiling - 1) / tiling + 1;
        e.name  = nm;
        return e;
    endfunction

    // Issue one operation, push its expectation, wait for valid, pop and compare.
    task automatic run_op(input int sel, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic md, input logic hold, input string nm);
        exp_t e;
        int   edges;
        bit   done;
        dut_sel = sel;
        a = av; b = bv; mode = md; start = 1'b1;
        sb.push_back(model(av, bv, md, (sel == 1) ? 2 : 1, nm));
        @(posedge clk); #1;
        edges = 1;
        checks++;
        if (obs_busy !== 1'b1 || obs_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s accept: busy=%b valid=%b expected busy=1 valid=0", nm, obs_busy, obs_valid);
        end
        if (!hold) start = 1'b0;
        a = ~av; b = {bv[7:0], bv[W-1:8]} ^ {W{1'b1}}; mode = ~md;
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(posedge clk); #1;
            edges++;
            if (obs_valid === 1'b1) done = 1;
        end
        start = 1'b0;
        e = sb.pop_front();
        checks++;
        if (!done) begin
            errors++;
            $display("[TB] FAIL %s timeout: valid not seen after %0d edges, expected by %0d", nm, edges, e.edges);
        end else begin
            if (edges !== e.edges) begin
                errors++;
                $display("[TB] FAIL %s latency: got %0d edges expected %0d", nm, edges, e.edges);
            end
            checks++;
            if (obs_result !== e.result) begin
                errors++;
                $display("[TB] FAIL %s result: got %h expected %h", nm, obs_result, e.result);
            end
            checks++;
            if (obs_dot !== e.dot) begin
                errors++;
                $display("[TB] FAIL %s dot: got %h expected %h", nm, obs_dot, e.dot);
            end
            checks++;
            if (obs_mask !== e.mask || obs_error !== e.err) begin
                errors++;
                $display("[TB] FAIL %s flags: got mask=%b error=%b expected mask=%b error=%b",
                         nm, obs_mask, obs_error, e.mask, e.err);
            end
            checks++;
            if (obs_busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL %s busy_done: got %b expected 0", nm, obs_busy);
            end
        end
    endtask

    task automatic check_all_zero(input string nm);
        checks++;
        if (obs_busy !== 1'b0 || obs_valid !== 1'b0 || obs_error !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s ctrl: got busy=%b valid=%b error=%b expected 0 0 0", nm, obs_busy, obs_valid, obs_error);
        end
        checks++;
        if (obs_result !== '0 || obs_dot !== 8'h00 || obs_mask !== '0) begin
            errors++;
            $display("[TB] FAIL %s data: got result=%h dot=%h mask=%b expected zeros", nm, obs_result, obs_dot, obs_mask);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; a = '0; b = '0;
        #12;
        dut_sel = 0; #1;
        check_all_zero("reset_t1");
        dut_sel = 1; #1;
        check_all_zero("reset_t2");
        dut_sel = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_elementwise();
        logic [W-1:0] bv;
        bv = {8'h7F, 8'h01, 8'hF0, 8'h08, 8'h20};
        run_op(0, {VL{8'h10}}, bv, 1'b0, 1'b0, "elementwise");
        checks++;
        if (obs_result !== bv || obs_error !== 1'b0) begin
            errors++;
            $display("[TB] FAIL elem_identity: got %h error=%b expected %h error=0", obs_result, obs_error, bv);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] lane0;
`ifdef VECTOR_OP_SATURATE_EN
        lane0 = 8'h7F;
`else
        lane0 = 8'hF0;
`endif
        run_op(0, {{4{8'h10}}, 8'h7F}, {{4{8'h10}}, 8'h7F}, 1'b0, 1'b0, "overflow_lane0");
        checks++;
        if (obs_result[7:0] !== lane0 || obs_mask !== 5'b00001 || obs_error !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_lane0: got lane0=%h mask=%b error=%b expected %h 00001 1",
                     obs_result[7:0], obs_mask, obs_error, lane0);
        end
    endtask

    task automatic test_negative();
        run_op(0, {{3{8'h10}}, 8'hF0, 8'h10}, {{3{8'h10}}, 8'h20, 8'h10}, 1'b0, 1'b0, "negative");
        checks++;
        if (obs_result[15:8] !== 8'hE0 || obs_mask !== 5'b00000) begin
            errors++;
            $display("[TB] FAIL neg_lane1: got %h mask=%b expected e0 00000", obs_result[15:8], obs_mask);
        end
    endtask

    task automatic test_dot();
        run_op(0, {VL{8'h10}}, {VL{8'h10}}, 1'b1, 1'b0, "dot");
        checks++;
        if (obs_dot !== 8'h50 || obs_result !== {VL{8'h10}}) begin
            errors++;
            $display("[TB] FAIL dot_value: got dot=%h result=%h expected 50 %h", obs_dot, obs_result, {VL{8'h10}});
        end
        run_op(0, {VL{8'h40}}, {VL{8'h40}}, 1'b1, 1'b0, "dot_overflow");
        checks++;
        if (obs_error !== 1'b1) begin
            errors++;
            $display("[TB] FAIL dot_ovf_error: got %b expected 1", obs_error);
        end
    endtask

    task automatic test_tiling();
        run_op(1, {8'h30, 8'hE8, 8'h7F, 8'h10, 8'h20}, {8'h18, 8'h40, 8'h7F, 8'hF0, 8'h30}, 1'b1, 1'b0, "tiling2_dot");
        run_op(1, {8'h11, 8'h22, 8'h33, 8'h44, 8'h55}, {8'hF1, 8'h02, 8'hC3, 8'h04, 8'h05}, 1'b0, 1'b0, "tiling2_elem");
        dut_sel = 0;
    endtask

    task automatic test_start_held();
        run_op(0, {8'h12, 8'h34, 8'hF6, 8'h08, 8'h19}, {8'h21, 8'hE3, 8'h15, 8'h70, 8'h0A}, 1'b1, 1'b1, "start_held");
    endtask

    task automatic test_back_to_back();
        run_op(0, {8'h20, 8'h20, 8'h20, 8'h20, 8'h20}, {8'h01, 8'h02, 8'h03, 8'h04, 8'h05}, 1'b0, 1'b0, "b2b_first");
        run_op(0, {8'hF8, 8'h18, 8'h28, 8'hC8, 8'h08}, {8'h30, 8'hD0, 8'h10, 8'h10, 8'h60}, 1'b1, 1'b0, "b2b_second");
        run_op(1, {8'h7F, 8'h80, 8'h01, 8'hFF, 8'h40}, {8'h7F, 8'h80, 8'h01, 8'hFF, 8'hC0}, 1'b1, 1'b0, "b2b_tiling2");
        dut_sel = 0;
    endtask

    task automatic test_reset_mid_run();
        dut_sel = 0;
        a = {VL{8'h20}}; b = {VL{8'h30}}; mode = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid_run");
        @(negedge clk);
        rst_n = 1'b1;
        run_op(0, {VL{8'h18}}, {8'h10, 8'h20, 8'h30, 8'hF0, 8'h08}, 1'b1, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_elementwise();
        test_overflow();
        test_negative();
        test_dot();
        test_tiling();
        test_start_held();
        test_back_to_back();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
